// File: rtl/perm_sched_pkg.sv
// Shared types and constants for the permutation read scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package perm_sched_pkg;

    // Scheduler control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Deepest supported bank read latency
    localparam int RD_LAT_MAX = 4;

    // Number of memory banks feeding the rotator
    localparam int N_BANKS = 4;

    // Width of the rotation amount (log2 of the bank count)
    localparam int ROT_W = 2;

endpackage

// File: rtl/perm_sched_dly.sv
// perm_dly: fixed-depth shift register carrying a valid bit and a data word.
// Latency: DEPTH cycles from input to output.
// Backpressure: none; shifts every cycle, idle cycles travel as valid=0 bubbles.
module perm_dly #(
    parameter int DEPTH = 1,
    parameter int W     = 2
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    output logic         o_pend
);

    logic [DEPTH-1:0] r_vld;
    logic [W-1:0]     r_dat [DEPTH];

    // Shift valid and data one stage per cycle; synchronous clear
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_dat[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_dat = r_dat[DEPTH-1];

    // o_pend flags valid entries that have not yet reached the output stage
    generate
        if (DEPTH > 1) begin : g_pend
            assign o_pend = |r_vld[DEPTH-2:0];
        end else begin : g_nopend
            assign o_pend = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/perm_sched.sv
// perm_sched: issues skewed or straight reads to four banks and tracks rotator select.
// Latency: RE/addresses one cycle after the issue decision; SEL/VLD RD_LAT cycles after RE.
// Backpressure: STALL drops RE and holds the issue counter; the select delay line keeps shifting.
module perm_sched
    import perm_sched_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_len,
    input  logic              i_mode,
    input  logic              i_stall,
    output logic              o_re,
    output logic [ADDR_W-1:0] o_a0,
    output logic [ADDR_W-1:0] o_a1,
    output logic [ADDR_W-1:0] o_a2,
    output logic [ADDR_W-1:0] o_a3,
    output logic [1:0]        o_sel,
    output logic              o_vld,
    output logic              o_busy,
    output logic              o_done
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] r_len;
    logic              r_mode;
    logic              r_re;
    logic [ADDR_W-1:0] r_a [N_BANKS];
    logic [ROT_W-1:0]  r_rot;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_base;
    logic [ROT_W-1:0]  w_off  [N_BANKS];
    logic [ADDR_W-1:0] w_addr [N_BANKS];
    logic [ROT_W-1:0]  w_rot;
    logic              w_last;
    logic              w_dly_vld;
    logic              w_dly_pend;
    logic [ROT_W-1:0]  w_dly_dat;

    // Per-bank address and rotation for the current issue index k.
    // Skewed: bank b reads row-group base plus (b - k) mod 4, so the four
    // banks together cover one aligned group of four words rotated by k[1:0].
    always_comb begin
        w_base = {r_k[ADDR_W-1:2], 2'b00};
        w_rot  = r_mode ? '0 : r_k[1:0];
        w_last = (r_k == r_len);
        for (int b = 0; b < N_BANKS; b++) begin
            w_off[b]  = ROT_W'(b) - r_k[1:0];
            w_addr[b] = r_mode ? r_k : (w_base + {{(ADDR_W-ROT_W){1'b0}}, w_off[b]});
        end
    end

    // Control FSM with registered read-issue, busy and done outputs
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_len   <= '0;
            r_mode  <= 1'b0;
            r_re    <= 1'b0;
            r_rot   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int b = 0; b < N_BANKS; b++) begin
                r_a[b] <= '0;
            end
        end else begin
            // RE and rotation are single-cycle; rotation is zeroed when idle
            // so the delayed select reads 0 on bubbles.
            r_re   <= 1'b0;
            r_rot  <= '0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_len   <= i_len;
                        r_mode  <= i_mode;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!i_stall) begin
                        r_re  <= 1'b1;
                        r_rot <= w_rot;
                        for (int b = 0; b < N_BANKS; b++) begin
                            r_a[b] <= w_addr[b];
                        end
                        // Wraps to 0 only after the maximum-length pass
                        r_k <= r_k + 1'b1;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Last read is in flight until neither RE nor an inner
                    // delay stage holds it; the output stage is emitting it now.
                    if (!r_re && !w_dly_pend) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Delay rotation alongside RE to line up with bank read data
    perm_dly #(
        .DEPTH (RD_LAT),
        .W     (ROT_W)
    ) u_dly (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_vld  (r_re),
        .i_dat  (r_rot),
        .o_vld  (w_dly_vld),
        .o_dat  (w_dly_dat),
        .o_pend (w_dly_pend)
    );

    assign o_re   = r_re;
    assign o_a0   = r_a[0];
    assign o_a1   = r_a[1];
    assign o_a2   = r_a[2];
    assign o_a3   = r_a[3];
    assign o_sel  = w_dly_dat;
    assign o_vld  = w_dly_vld;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_perm_sched.sv
// Testbench for perm_sched: two instances (RD_LAT=1 and RD_LAT=3) share stimulus.
// Expected outputs come from a cycle timeline built from the issue/stall rules.
`timescale 1ns/1ps
module tb_perm_sched;

    localparam int AW   = 8;
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          start;
    logic [AW-1:0] len;
    logic          mode;
    logic          stall;

    logic          re1, vld1, busy1, done1;
    logic [1:0]    sel1;
    logic [AW-1:0] a10, a11, a12, a13;
    logic          re3, vld3, busy3, done3;
    logic [1:0]    sel3;
    logic [AW-1:0] a30, a31, a32, a33;

    perm_sched #(.ADDR_W(AW), .RD_LAT(1)) u_lat1 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_len(len), .i_mode(mode), .i_stall(stall),
        .o_re(re1), .o_a0(a10), .o_a1(a11), .o_a2(a12), .o_a3(a13),
        .o_sel(sel1), .o_vld(vld1), .o_busy(busy1), .o_done(done1)
    );

    perm_sched #(.ADDR_W(AW), .RD_LAT(3)) u_lat3 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_len(len), .i_mode(mode), .i_stall(stall),
        .o_re(re3), .o_a0(a30), .o_a1(a31), .o_a2(a32), .o_a3(a33),
        .o_sel(sel3), .o_vld(vld3), .o_busy(busy3), .o_done(done3)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: addresses currently held on the bank ports
    logic [AW-1:0] m_a [4];

    // Per-cycle expectations for one pass
    bit         e_re  [MAXC];
    int         e_idx [MAXC];
    bit         e_v1  [MAXC];
    bit         e_v3  [MAXC];
    logic [1:0] e_s1  [MAXC];
    logic [1:0] e_s3  [MAXC];
    bit         stl   [MAXC];

    // Observations collected during the last pass
    int obs_a1 [4];
    int obs_v1, obs_v3;
    int obs_re_last1, obs_re_last3, obs_v1_first, obs_v1_last, obs_v3_last, obs_done1_c, obs_done3_c;
    int obs_sel_q [$];

    // Address bank b reads for element k, straight from the skew rule
    function automatic logic [AW-1:0] bank_a(input int k, input int b, input bit md);
        int grp;
        if (md) return AW'(k % 256);
        grp = (k % 256) / 4;
        return AW'((grp * 4 + ((b - (k % 4) + 4) % 4)) % 256);
    endfunction

    task automatic run_pass(input string name, input int plen, input bit pmode, input int stall_pct,
                            input int st_from, input int st_n, input bit glitch);
        int iss [$];
        int t;
        int last;
        logic [1:0] r;
        bit eb1, eb3;
        for (int c = 0; c < MAXC; c++) begin
            stl[c] = 1'b0; e_re[c] = 1'b0; e_idx[c] = 0;
            e_v1[c] = 1'b0; e_v3[c] = 1'b0; e_s1[c] = 2'd0; e_s3[c] = 2'd0;
        end
        for (int c = 1; c < MAXC; c++) begin
            if (c >= st_from && c < st_from + st_n) stl[c] = 1'b1;
            else if ($urandom_range(99) < stall_pct) stl[c] = 1'b1;
        end
        // A non-stalled cycle t in RUN yields a read visible in cycle t+1
        t = 1;
        while (iss.size() <= plen && t < MAXC - 16) begin
            if (!stl[t]) iss.push_back(t + 1);
            t++;
        end
        foreach (iss[i]) begin
            r = pmode ? 2'd0 : 2'(i % 4);
            e_re[iss[i]] = 1'b1;  e_idx[iss[i]] = i;
            e_v1[iss[i] + 1] = 1'b1; e_s1[iss[i] + 1] = r;
            e_v3[iss[i] + 3] = 1'b1; e_s3[iss[i] + 3] = r;
        end
        last = iss[iss.size() - 1];
        obs_v1 = 0; obs_v3 = 0; obs_re_last1 = -1; obs_re_last3 = -1;
        obs_v1_first = -1; obs_v1_last = -1; obs_v3_last = -1; obs_done1_c = -1; obs_done3_c = -1;
        obs_sel_q.delete();
        for (int b = 0; b < 4; b++) obs_a1[b] = -1;

        for (int c = 0; c <= last + 5; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (glitch && (c == 2 || c == last));
            if (c == 0) begin len = AW'(plen); mode = pmode; end
            else begin len = AW'($urandom); mode = 1'($urandom_range(1)); end
            stall = stl[c];
            @(negedge clk);
            if (e_re[c]) for (int b = 0; b < 4; b++) m_a[b] = bank_a(e_idx[c], b, pmode);

            n_checks++;
            if ({re1, a10, a11, a12, a13} !== {e_re[c], m_a[0], m_a[1], m_a[2], m_a[3]}) begin
                n_errors++;
                $display("FAIL %s issue_lat1 c=%0d: got re=%0b a=%0d,%0d,%0d,%0d want re=%0b a=%0d,%0d,%0d,%0d",
                         name, c, re1, a10, a11, a12, a13, e_re[c], m_a[0], m_a[1], m_a[2], m_a[3]);
            end
            n_checks++;
            if ({re3, a30, a31, a32, a33} !== {e_re[c], m_a[0], m_a[1], m_a[2], m_a[3]}) begin
                n_errors++;
                $display("FAIL %s issue_lat3 c=%0d: got re=%0b a=%0d,%0d,%0d,%0d want re=%0b a=%0d,%0d,%0d,%0d",
                         name, c, re3, a30, a31, a32, a33, e_re[c], m_a[0], m_a[1], m_a[2], m_a[3]);
            end
            n_checks++;
            if ({vld1, sel1, done1} !== {e_v1[c], e_s1[c], (c == last + 2)}) begin
                n_errors++;
                $display("FAIL %s out_lat1 c=%0d: got vld=%0b sel=%0d done=%0b want vld=%0b sel=%0d done=%0b",
                         name, c, vld1, sel1, done1, e_v1[c], e_s1[c], (c == last + 2));
            end
            n_checks++;
            if ({vld3, sel3, done3} !== {e_v3[c], e_s3[c], (c == last + 4)}) begin
                n_errors++;
                $display("FAIL %s out_lat3 c=%0d: got vld=%0b sel=%0d done=%0b want vld=%0b sel=%0d done=%0b",
                         name, c, vld3, sel3, done3, e_v3[c], e_s3[c], (c == last + 4));
            end
            // Busy from the cycle after START through the last valid output
            eb1 = (c >= 1 && c <= last + 1);
            if (c <= last + 1 || c >= last + 3) begin
                n_checks++;
                if (busy1 !== eb1) begin
                    n_errors++;
                    $display("FAIL %s busy_lat1 c=%0d: got %0b want %0b", name, c, busy1, eb1);
                end
            end
            eb3 = (c >= 1 && c <= last + 3);
            if (c <= last + 3 || c >= last + 5) begin
                n_checks++;
                if (busy3 !== eb3) begin
                    n_errors++;
                    $display("FAIL %s busy_lat3 c=%0d: got %0b want %0b", name, c, busy3, eb3);
                end
            end

            if (re1) obs_re_last1 = c;
            if (re3) obs_re_last3 = c;
            if (re1 && e_re[c] && e_idx[c] == 1) begin
                obs_a1[0] = int'(a10); obs_a1[1] = int'(a11); obs_a1[2] = int'(a12); obs_a1[3] = int'(a13);
            end
            if (vld1) begin
                obs_v1++; obs_v1_last = c; obs_sel_q.push_back(int'(sel1));
                if (obs_v1_first < 0) obs_v1_first = c;
            end
            if (vld3) begin obs_v3++; obs_v3_last = c; end
            if (done1) obs_done1_c = c;
            if (done3) obs_done3_c = c;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b1; len = 8'd5; mode = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({re1, a10, a11, a12, a13, sel1, vld1, busy1, done1, re3, a30, a31, a32, a33, sel3, vld3, busy3, done3} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got re=%0b busy=%0b vld=%0b / re=%0b busy=%0b vld=%0b want all 0",
                     re1, busy1, vld1, re3, busy3, vld3);
        end
        @(posedge clk); #1 rstn = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy1, re1, busy3, re3} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_start_discard: got busy=%0b re=%0b / busy=%0b re=%0b want 0", busy1, re1, busy3, re3);
        end
        for (int b = 0; b < 4; b++) m_a[b] = '0;
    endtask

    task automatic test_skew();
        logic [15:0] got;
        run_pass("skew", 7, 1'b0, 0, 0, 0, 1'b0);
        n_checks++;
        if (obs_a1[0] != 3 || obs_a1[1] != 0 || obs_a1[2] != 1 || obs_a1[3] != 2) begin
            n_errors++;
            $display("FAIL skew_k1_addr: got %0d,%0d,%0d,%0d want 3,0,1,2", obs_a1[0], obs_a1[1], obs_a1[2], obs_a1[3]);
        end
        got = '0;
        foreach (obs_sel_q[i]) got = {got[13:0], 2'(obs_sel_q[i])};
        n_checks++;
        if (obs_sel_q.size() != 8 || got !== 16'h1B1B) begin
            n_errors++;
            $display("FAIL skew_sel_seq: got n=%0d seq=%h want n=8 seq=1b1b", obs_sel_q.size(), got);
        end
        n_checks++;
        if (obs_done1_c - obs_re_last1 != 2) begin
            n_errors++;
            $display("FAIL skew_done_gap: got %0d want 2", obs_done1_c - obs_re_last1);
        end
    endtask

    task automatic test_straight();
        run_pass("straight", 3, 1'b1, 0, 0, 0, 1'b0);
        n_checks++;
        if (obs_v1 != 4 || obs_v3 != 4) begin
            n_errors++;
            $display("FAIL straight_vld_count: got %0d/%0d want 4/4", obs_v1, obs_v3);
        end
    endtask

    task automatic test_stall();
        logic [11:0] got;
        // Stall sampled in cycles 3 and 4, right after the second read
        run_pass("stall", 5, 1'b0, 0, 3, 2, 1'b0);
        n_checks++;
        if ((obs_v1_last - obs_v1_first + 1) - obs_v1 != 2) begin
            n_errors++;
            $display("FAIL stall_bubbles: got %0d want 2", (obs_v1_last - obs_v1_first + 1) - obs_v1);
        end
        got = '0;
        foreach (obs_sel_q[i]) got = {got[9:0], 2'(obs_sel_q[i])};
        n_checks++;
        if (obs_sel_q.size() != 6 || got !== 12'b00_01_10_11_00_01) begin
            n_errors++;
            $display("FAIL stall_sel_seq: got n=%0d seq=%h want n=6 seq=1b1", obs_sel_q.size(), got);
        end
    endtask

    task automatic test_single();
        run_pass("single", 0, 1'b0, 0, 0, 0, 1'b0);
        n_checks++;
        if (obs_v3 != 1 || obs_v3_last - obs_re_last3 != 3 || obs_done3_c - obs_v3_last != 1) begin
            n_errors++;
            $display("FAIL single_lat3: got nvld=%0d re->vld=%0d vld->done=%0d want 1,3,1",
                     obs_v3, obs_v3_last - obs_re_last3, obs_done3_c - obs_v3_last);
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1 start = 1'b1; len = 8'd20; mode = 1'b0; stall = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rstn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (re1 !== 1'b1 || busy1 !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_running: got re=%0b busy=%0b want 1,1", re1, busy1);
        end
        @(negedge clk);
        n_checks++;
        if ({re1, a10, a11, a12, a13, sel1, vld1, busy1, done1, re3, a30, a31, a32, a33, sel3, vld3, busy3, done3} !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got re=%0b a1=%0d busy=%0b / re=%0b busy=%0b want all 0",
                     re1, a11, busy1, re3, busy3);
        end
        @(posedge clk); #1 rstn = 1'b1;
        for (int b = 0; b < 4; b++) m_a[b] = '0;
        @(negedge clk);
        run_pass("after_reset", 10, 1'b0, 20, 0, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_pass("glitch_skew", 9, 1'b0, 25, 0, 0, 1'b1);
        run_pass("glitch_straight", 6, 1'b1, 25, 0, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_pass("random", $urandom_range(0, 40), 1'($urandom_range(1)), $urandom_range(0, 50), 0, 0,
                     1'($urandom_range(1)));
        end
    endtask

    task automatic test_max_len();
        run_pass("max_skew", 255, 1'b0, 10, 0, 0, 1'b0);
        run_pass("max_straight", 255, 1'b1, 10, 0, 0, 1'b0);
        run_pass("post_max", 4, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_skew();
        test_straight();
        test_stall();
        test_single();
        test_mid_reset();
        test_start_ignored();
        test_random();
        test_max_len();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/perm_sched.md
PERM_SCHED -- requirements
Module: perm_sched

Interface
REQ-001 Parameter ADDR_W, default 8: bank address width and count width.
REQ-002 Parameter RD_LAT, default 1: bank read latency in cycles, from RE/address to data at the rotator input; legal range 1..4.
REQ-003 CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 RSTN  in  1  reset; synchronous and active-low.
REQ-005 START  in  1  one-cycle request to begin a pass; sampled only in IDLE.
REQ-006 LEN  in  ADDR_W  pass length minus one; sampled with START.
REQ-007 MODE  in  1  0 = skewed (rotating) pass, 1 = straight pass; sampled with START.
REQ-008 STALL  in  1  downstream hold; freezes read issue.
REQ-009 RE  out  1  read enable to all four banks.
REQ-010 A0, A1, A2, A3  out  ADDR_W each  per-bank read address.
REQ-011 SEL  out  2  rotator select, aligned to bank read data.
REQ-012 VLD  out  1  rotator output valid, aligned with SEL.
REQ-013 BUSY  out  1  high from the cycle after accepted START until DONE.
REQ-014 DONE  out  1  one-cycle pulse at pass end.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN, FIN; encoding is free.
REQ-016 IDLE->RUN on START; LEN and MODE are latched and issue counter k is cleared to 0; START outside IDLE is ignored.
REQ-017 RUN: each cycle with STALL=0 asserts RE, drives the addresses for k, and increments k; with STALL=1, RE=0 and k is held.
REQ-018 MODE=0: Ab = {k[ADDR_W-1:2],2'b00} + ((b - k[1:0]) mod 4), with the sum truncated to ADDR_W bits; issued rotation r = k[1:0].
REQ-019 MODE=1: A0..A3 = k; issued rotation r = 0.
REQ-020 RUN->DRAIN on the non-stalled issue where k == LEN; LEN=0 issues exactly one read.
REQ-021 A delay line RD_LAT deep carries {RE, r}; SEL and VLD are its output, so SEL equals the r issued RD_LAT cycles earlier.
REQ-022 The delay line shifts every cycle regardless of STALL; stalled cycles insert VLD=0 bubbles.
REQ-023 DRAIN->FIN when the delay line holds no valid entry; FIN drives DONE=1 for one cycle, then returns to IDLE.
REQ-024 The last VLD=1 occurs exactly RD_LAT cycles after the last RE=1; DONE follows in the next cycle.
REQ-025 When RE=0, A0..A3 hold their last values; when VLD=0, SEL is 0.
REQ-026 k wraps modulo 2^ADDR_W only when LEN = 2^ADDR_W-1, which is the maximum-length pass.

Reset
REQ-027 RSTN=0 at a clock edge forces IDLE and k=0, clears the delay line, and sets RE, A0..A3, SEL, VLD, BUSY and DONE to 0, including mid-pass.
REQ-028 A START asserted in the same cycle as RSTN=0 is discarded.

Structure
REQ-029 The FSM state typedef, the RD_LAT maximum (4) and the bank count (4) belong in the shared FFT package.
REQ-030 The delay line is one sub-module, perm_dly, parameterised by depth and width; the rotator itself is not instantiated here.

Verification
REQ-031 MODE=0, LEN=7, STALL=0, RD_LAT=1 -> cycle k=1: A0..A3 = 3,0,1,2; SEL sequence 0,1,2,3,0,1,2,3 starts one cycle after first RE; DONE two cycles after last RE.
REQ-032 MODE=1, LEN=3 -> A0..A3 = 0,1,2,3 on successive cycles; SEL=0 throughout; exactly 4 VLD pulses.
REQ-033 MODE=0, LEN=5, STALL high for 2 cycles after second issue -> k frozen; 2 VLD bubbles; SEL sequence with bubbles removed is 0,1,2,3,0,1.
REQ-034 RD_LAT=3, LEN=0 -> one RE; VLD exactly 3 cycles later with SEL=0; DONE the next cycle.
REQ-035 RSTN=0 during RUN at k=2 -> next cycle all outputs are 0 and the FSM is in IDLE; a new START runs a complete pass normally.
REQ-036 START pulsed during RUN and during DRAIN -> ignored; LEN and MODE are unchanged and the pass completes as originally programmed.
